// File: rtl/hcsr04_pkg.sv
// Shared constants for the HC-SR04 responder: one-hot state codes, echo timing
// factors and burst shape (burst used only when HCSR04_RESP_BURST_EN is defined).
package hcsr04_pkg;

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_TRIG  = 5'b00010;
  localparam logic [4:0] S_BURST = 5'b00100;
  localparam logic [4:0] S_ECHO  = 5'b01000;
  localparam logic [4:0] S_GUARD = 5'b10000;

  localparam logic [15:0] US_PER_CM       = 16'd58;
  localparam logic [8:0]  MAX_CM          = 9'd400;
  localparam logic [8:0]  MIN_CM          = 9'd2;
  localparam logic [15:0] TIMEOUT_US      = 16'd38000;
  localparam logic [15:0] TRIG_TIMEOUT_US = 16'd1000;

  localparam logic [4:0] BURST_HIGH_US    = 5'd12;
  localparam logic [4:0] BURST_LAST_PHASE = 5'd24;
  localparam logic [3:0] BURST_PULSES     = 4'd8;

  // Below the sensor's minimum range the echo reports MIN_CM; beyond MAX_CM it emulates a timeout.
  function automatic logic [15:0] echo_target(input logic [8:0] d);
    if (d < MIN_CM)
      return 16'({7'b0, MIN_CM} * US_PER_CM);
    else if (d > MAX_CM)
      return TIMEOUT_US;
    else
      return 16'({7'b0, d} * US_PER_CM);
  endfunction

endpackage

// File: rtl/clock_usec.sv
// Free-running divider producing a one-clk tick every CLK_FREQ_HZ/1_000_000 clocks.
module clock_usec #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset_p,
  output logic tick
);

  localparam int unsigned DIV  = (CLK_FREQ_HZ / 1_000_000 > 0) ? CLK_FREQ_HZ / 1_000_000 : 1;
  localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hcsr04_responder.sv
// HC-SR04 ultrasonic sensor emulator: answers a trig pulse with an echo whose width
// encodes distance_cm. Define HCSR04_RESP_BURST_EN to emulate the 40 kHz transducer burst.
module hcsr04_responder
  import hcsr04_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned LEAD_US     = 250,
  parameter int unsigned GUARD_US    = 10_000,
  parameter int unsigned TRIG_MIN_US = 10
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       trig,
  input  logic [8:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       short_trig,
  output logic       burst
);

  localparam logic [15:0] LEAD     = 16'(LEAD_US);
  localparam logic [15:0] GUARD    = 16'(GUARD_US);
  localparam logic [15:0] TRIG_MIN = 16'(TRIG_MIN_US);

  logic        tick;
  logic        trig_s1, trig_s2, trig_d;
  logic        trig_rise, trig_fall;
  logic [4:0]  state, state_next;
  logic [15:0] counter, count_now, target;
  logic        short_next;

  clock_usec #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_clock_usec (
    .clk     (clk),
    .reset_p (reset_p),
    .tick    (tick)
  );

  assign trig_rise = trig_s2 & ~trig_d;
  assign trig_fall = ~trig_s2 & trig_d;
  // Compare against the value the counter is about to take so every interval is exact in us.
  assign count_now = counter + {15'b0, tick};
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_next = state;
    short_next = 1'b0;
    case (state)
      S_IDLE:  if (trig_rise) state_next = S_TRIG;
      S_TRIG: begin
        if (trig_fall) begin
          if (count_now >= TRIG_MIN) begin
            state_next = S_BURST;
          end else begin
            state_next = S_IDLE;
            short_next = 1'b1;
          end
        end else if (count_now >= TRIG_TIMEOUT_US) begin
          state_next = S_IDLE;
        end
      end
      S_BURST: if (count_now == LEAD)   state_next = S_ECHO;
      S_ECHO:  if (count_now == target) state_next = S_GUARD;
      S_GUARD: if (count_now == GUARD)  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      trig_s1    <= 1'b0;
      trig_s2    <= 1'b0;
      trig_d     <= 1'b0;
      state      <= S_IDLE;
      counter    <= '0;
      target     <= '0;
      echo       <= 1'b0;
      short_trig <= 1'b0;
    end else begin
      trig_s1    <= trig;
      trig_s2    <= trig_s1;
      trig_d     <= trig_s2;
      state      <= state_next;
      counter    <= (state_next != state) ? '0 : count_now;
      echo       <= (state_next == S_ECHO);
      short_trig <= short_next;
      if (state == S_TRIG && state_next == S_BURST)
        target <= echo_target(distance_cm);
    end
  end

`ifdef HCSR04_RESP_BURST_EN
  logic [4:0] phase;
  logic [3:0] periods;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      phase   <= '0;
      periods <= '0;
      burst   <= 1'b0;
    end else if (state != S_BURST) begin
      phase   <= '0;
      periods <= '0;
      burst   <= 1'b0;
    end else begin
      burst <= (periods < BURST_PULSES) && (phase < BURST_HIGH_US);
      if (tick) begin
        if (phase == BURST_LAST_PHASE) begin
          phase <= '0;
          if (periods < BURST_PULSES) periods <= periods + 1'b1;
        end else begin
          phase <= phase + 1'b1;
        end
      end
    end
  end
`else
  assign burst = 1'b0;
`endif

endmodule

// File: tb/tb_hcsr04_responder.sv
// Randomized self-checking bench for hcsr04_responder; 1 MHz clock so one clk equals one us.
module tb_hcsr04_responder;

  localparam int LEAD  = 250;
  localparam int GUARD = 500;
  localparam int TMIN  = 10;

  logic       clk = 1'b0;
  logic       reset_p;
  logic       trig;
  logic [8:0] distance_cm;
  logic       echo, busy, short_trig, burst;

  int n_checks  = 0;
  int n_errors  = 0;
  int short_cnt = 0;

  hcsr04_responder #(
    .CLK_FREQ_HZ (1_000_000),
    .LEAD_US     (LEAD),
    .GUARD_US    (GUARD),
    .TRIG_MIN_US (TMIN)
  ) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .trig        (trig),
    .distance_cm (distance_cm),
    .echo        (echo),
    .busy        (busy),
    .short_trig  (short_trig),
    .burst       (burst)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (short_trig) short_cnt++;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference echo width in us from the distance rules.
  function automatic int model_width(input int d);
    if (d < 2)   return 116;
    if (d > 400) return 38000;
    return d * 58;
  endfunction

  // Collapses a value within tolerance onto its expected value so check() reports the raw value otherwise.
  function automatic int near(input int got, input int exp, input int tol);
    return (got >= exp - tol && got <= exp + tol) ? exp : got;
  endfunction

  task automatic trig_pulse(input int w);
    @(negedge clk);
    trig = 1'b1;
    repeat (w) @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic run_cycle(input string tag, input int w, input int d, input bit inject);
    int lead, width, guard, rises, bad_gap, last_rise, low_busy, idle_busy, sc0;
    logic pb;
    distance_cm = 9'(d);
    sc0 = short_cnt;
    trig_pulse(w);
    lead = 0; rises = 0; bad_gap = 0; last_rise = -1; pb = 1'b0; low_busy = 0;
    while (!echo && lead < 3000) begin
      @(negedge clk);
      lead++;
      if (burst && !pb) begin
        if (last_rise >= 0 && lead - last_rise != 25) bad_gap++;
        last_rise = lead;
        rises++;
      end
      pb = burst;
      if (lead > 4 && !busy) low_busy++;
    end
    // Trig fall to echo rise is LEAD plus a few clks of synchronizer and edge-detect latency.
    check({tag, "_lead"}, near(lead, LEAD + 2, 2), LEAD + 2);
`ifdef HCSR04_RESP_BURST_EN
    check({tag, "_burst_rises"}, rises, 8);
    check({tag, "_burst_gap"}, bad_gap, 0);
`else
    check({tag, "_burst_rises"}, rises, 0);
`endif
    width = 0;
    while (echo && width < 40000) begin
      @(negedge clk);
      width++;
      if (!busy) low_busy++;
      if (inject && width == 100) trig = 1'b1;
      if (inject && width == 110) begin
        trig = 1'b0;
        distance_cm = 9'd20;
      end
    end
    check({tag, "_width"}, near(width, model_width(d), 1), model_width(d));
    guard = 0;
    while (busy && guard < GUARD + 100) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_guard"}, near(guard, GUARD, 1), GUARD);
    check({tag, "_busy_gap"}, low_busy, 0);
    idle_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || echo) idle_busy++;
    end
    check({tag, "_no_retrigger"}, idle_busy, 0);
    check({tag, "_no_short"}, short_cnt - sc0, 0);
  endtask

  task automatic short_case(input string tag, input int w);
    int sc0, echo_hi;
    sc0 = short_cnt;
    echo_hi = 0;
    trig_pulse(w);
    repeat (3) begin
      @(negedge clk);
      if (echo) echo_hi++;
    end
    check({tag, "_busy_low"}, int'(busy), 0);
    repeat (20) begin
      @(negedge clk);
      if (echo || busy) echo_hi++;
    end
    check({tag, "_short_pulse"}, short_cnt - sc0, 1);
    check({tag, "_no_echo"}, echo_hi, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sc0, cnt, d;
    reset_p = 1'b1;
    trig = 1'b0;
    distance_cm = '0;
    repeat (3) @(negedge clk);
    check("rst_echo", int'(echo), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_short", int'(short_trig), 0);
    check("rst_burst", int'(burst), 0);
    reset_p = 1'b0;
    repeat (5) @(negedge clk);

    run_cycle("d100", 10, 100, 1'b0);
    short_case("w5", 5);
    short_case("w9", TMIN - 1);
    run_cycle("d450", 10, 450, 1'b0);
    run_cycle("d0", 10, 0, 1'b0);
    run_cycle("d2", 12, 2, 1'b0);
    run_cycle("inject", 10, 100, 1'b1);

    // Trig held past the S_TRIG timeout: back to idle silently and no restart while still high.
    sc0 = short_cnt;
    @(negedge clk);
    trig = 1'b1;
    repeat (1010) @(negedge clk);
    check("trig_to_idle", int'(busy), 0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    trig = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("trig_held_no_start", cnt, 0);
    check("trig_to_no_short", short_cnt - sc0, 0);

    // Reset 1000 us into an echo.
    distance_cm = 9'd100;
    trig_pulse(10);
    cnt = 0;
    while (!echo && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_mid_echo_seen", int'(echo), 1);
    repeat (1000) @(negedge clk);
    reset_p = 1'b1;
    #1;
    check("rst_mid_echo", int'(echo), 0);
    check("rst_mid_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    reset_p = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (echo || busy) cnt++;
    end
    check("rst_no_restart", cnt, 0);
    run_cycle("post_rst", 10, 20, 1'b0);

    for (int i = 0; i < 5; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        short_case("rnd_short", int'($urandom_range(1, TMIN - 1)));
      end else begin
        d = int'($urandom_range(0, 45));
        run_cycle("rnd", int'($urandom_range(TMIN, 40)), d, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hcsr04_responder.md
HCSR04_RESPONDER -- requirements
Module: hcsr04_responder

Interface
REQ-001 Parameter: CLK_FREQ_HZ, 100_000_000, system clock frequency used to derive the 1 us tick.
REQ-002 Parameter: LEAD_US, 250, delay in us from accepted trig falling edge to echo rising.
REQ-003 Parameter: GUARD_US, 10_000, post-echo hold-off in us during which trig is ignored.
REQ-004 Parameter: TRIG_MIN_US, 10, minimum accepted trig high width in us.
REQ-005 Port: clk  in  1  system clock; all flops rise-edge triggered.
REQ-006 Port: reset_p  in  1  reset, asynchronous, active-high.
REQ-007 Port: trig  in  1  asynchronous trigger pulse from the sensor controller.
REQ-008 Port: distance_cm  in  9  emulated target distance in cm, unsigned.
REQ-009 Port: echo  out  1  echo pulse whose width encodes distance (58 us/cm).
REQ-010 Port: busy  out  1  high whenever the state is not S_IDLE.
REQ-011 Port: short_trig  out  1  one-clk pulse when a trig shorter than TRIG_MIN_US is rejected.
REQ-012 Port: burst  out  1  emulated 40 kHz transducer burst (see Configuration).

Function
REQ-013 trig SHALL pass a 2-flop synchronizer; rise/fall edges SHALL be detected on the synchronized signal.
REQ-014 States SHALL be S_IDLE, S_TRIG, S_BURST, S_ECHO, S_GUARD, one-hot, default -> S_IDLE.
REQ-015 A single 16-bit us counter SHALL increment on each 1 us tick and clear to 0 on every state entry.
REQ-016 S_IDLE: trig rise -> S_TRIG.
REQ-017 S_TRIG: trig fall with counter >= TRIG_MIN_US -> S_BURST and latch distance_cm; fall with counter < TRIG_MIN_US -> S_IDLE and short_trig pulse.
REQ-018 S_TRIG: counter reaching 1000 without trig fall -> S_IDLE, no short_trig.
REQ-019 Echo width target (16-bit) SHALL be computed from latched distance: d<2 -> 116; 2<=d<=400 -> d*58; d>400 -> 38000 (timeout emulation).
REQ-020 S_BURST: counter == LEAD_US -> S_ECHO, echo <= 1 on the same clk edge.
REQ-021 S_ECHO: counter == target -> echo <= 0, S_GUARD; echo high time SHALL be target us +/-1 us.
REQ-022 S_GUARD: counter == GUARD_US -> S_IDLE.
REQ-023 trig edges in S_BURST, S_ECHO, S_GUARD SHALL be ignored; a trig still high on return to S_IDLE SHALL NOT start a cycle (rising edge required).
REQ-024 distance_cm changes after latch SHALL NOT affect the current echo.
REQ-025 echo and burst SHALL be registered outputs, glitch-free.

Reset
REQ-026 reset_p SHALL force state S_IDLE, counter 0, echo 0, busy 0, short_trig 0, burst 0, synchronizer flops 0.
REQ-027 reset_p asserted mid-echo SHALL drop echo to 0 immediately (asynchronously); after release, a new trig rise is required.

Configuration
REQ-028 With HCSR04_RESP_BURST_EN defined, burst SHALL toggle during S_BURST: 8 periods of 25 us (high 12 us, low 13 us) starting at S_BURST entry, then 0.
REQ-029 Without HCSR04_RESP_BURST_EN, burst SHALL be tied to 0 and its generation logic omitted; all other behaviour unchanged.

Structure
REQ-030 Shared package hcsr04_pkg SHALL hold the state encodings, the 58 us/cm factor, 400 cm maximum, 2 cm minimum and 38000 us timeout constants.
REQ-031 The 1 us tick SHALL come from an instance of clock_usec (one-clk pulse every CLK_FREQ_HZ/1_000_000 clks); no other sub-module.

Verification
REQ-032 trig high 10 us, distance_cm=100 -> echo rises 250 us after trig fall, stays high 5800 +/-1 us; busy high until 10 ms after echo fall.
REQ-033 trig high 5 us -> short_trig one-clk pulse, echo stays 0, busy low within 2 clks of trig fall.
REQ-034 distance_cm=450 -> echo high 38000 +/-1 us; distance_cm=0 -> echo high 116 +/-1 us.
REQ-035 Extra trig pulse and distance_cm change to 20 during S_ECHO of a 100 cm cycle -> echo width stays 5800 +/-1 us, no new cycle.
REQ-036 reset_p pulsed 1000 us into echo -> echo 0 same cycle, busy 0; next 10 us trig yields a normal cycle.
REQ-037 HCSR04_RESP_BURST_EN defined -> exactly 8 burst rising edges 25 us apart within S_BURST; undefined -> burst constant 0.
